regfile_wb_arbiter: RTL and testbench

Shares the single register-file write port between the in-order pipeline writeback stage and the long-latency multiply/divide unit (MDU). The pipeline has priority. MDU results wait in a 2-entry buffer until the port is free, and a starvation guard stalls writeback if an MDU result waits too long. The block sits between WB/MDU and the register file's `RegWrite` / `Write_register` / `Write_data` inputs, and exports a pending-destination mask to the hazard unit.

---
 rtl/regarb_pkg.sv | 33 +++
 rtl/regarb_buf.sv | 99 +++++++++
 rtl/regfile_wb_arbiter.sv | 186 ++++++++++++++++++
 tb/tb_regfile_wb_arbiter.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/regarb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : regarb_pkg
// Description : Shared types and constants for the register-file write-port
//               arbiter (regfile_wb_arbiter) and its MDU result buffer.
//               - regarb_entry_t : one buffered MDU result
//               - regarb_state_t : starvation-guard FSM states
//               - REG_ZERO       : architectural zero register
//               - reg_onehot()   : 5-bit register index to 32-bit mask bit
// Revision    : 1.0 - initial release
// ============================================================================
package regarb_pkg;

    localparam logic [4:0] REG_ZERO = 5'd0;

    typedef struct packed {
        logic        valid;
        logic [4:0]  rd;
        logic [31:0] data;
    } regarb_entry_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WAIT  = 2'd1,
        DRAIN = 2'd2
    } regarb_state_t;

    function automatic logic [31:0] reg_onehot(input logic [4:0] rd);
        return 32'd1 << rd;
    endfunction

endpackage
`default_nettype wire

// File: rtl/regarb_buf.sv
`default_nettype none
// ============================================================================
// Module      : regarb_buf
// Description : DEPTH-entry circular buffer of MDU results waiting for the
//               register-file write port.
//   clk, reset          : clock, synchronous active-high reset
//   push/push_rd/_data  : enqueue one result at the tail
//   pop                 : retire the head (granted or stale)
//   squash/squash_rd    : invalidate every entry targeting squash_rd
//   head_valid          : head holds a live result
//   head_stale          : head slot occupied but squashed (free pop)
//   head_rd/head_data   : head contents
//   full                : occupancy == DEPTH
//   pend_mask           : bit r set while a live entry targets register r
// Revision    : 1.0 - initial release
// ============================================================================
module regarb_buf
    import regarb_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        push,
    input  logic [4:0]  push_rd,
    input  logic [31:0] push_data,
    input  logic        pop,
    input  logic        squash,
    input  logic [4:0]  squash_rd,
    output logic        head_valid,
    output logic        head_stale,
    output logic [4:0]  head_rd,
    output logic [31:0] head_data,
    output logic        full,
    output logic [31:0] pend_mask
);

    localparam int                 c_PTR_W = $clog2(DEPTH);
    localparam logic [c_PTR_W:0]   c_FULL  = DEPTH[c_PTR_W:0];

    regarb_entry_t        r_entries [DEPTH];
    logic [c_PTR_W-1:0]   r_head;
    logic [c_PTR_W-1:0]   r_tail;
    logic [c_PTR_W:0]     r_count;
    logic                 w_occupied;

    assign w_occupied = (r_count != '0);
    assign head_valid = w_occupied && r_entries[r_head].valid;
    assign head_stale = w_occupied && !r_entries[r_head].valid;
    assign head_rd    = r_entries[r_head].rd;
    assign head_data  = r_entries[r_head].data;
    assign full       = (r_count == c_FULL);

    // Slots outside [head, tail) always have valid cleared, so the valid bit
    // alone identifies live entries.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_entries[i] <= '0;
            end
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (squash && r_entries[i].valid && (r_entries[i].rd == squash_rd)) begin
                    r_entries[i].valid <= 1'b0;
                end
            end
            if (pop) begin
                r_entries[r_head].valid <= 1'b0;
                r_head <= r_head + c_PTR_W'(1);
            end
            // The tail slot is never live when push is allowed, so this write
            // cannot collide with the squash or pop updates above.
            if (push) begin
                r_entries[r_tail] <= '{valid: 1'b1, rd: push_rd, data: push_data};
                r_tail <= r_tail + c_PTR_W'(1);
            end
            if (push && !pop) begin
                r_count <= r_count + (c_PTR_W + 1)'(1);
            end else if (!push && pop) begin
                r_count <= r_count - (c_PTR_W + 1)'(1);
            end
        end
    end

    always_comb begin
        pend_mask = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (r_entries[i].valid) begin
                pend_mask[r_entries[i].rd] = 1'b1;
            end
        end
        pend_mask[0] = 1'b0;
    end

endmodule
`default_nettype wire

// File: rtl/regfile_wb_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : regfile_wb_arbiter
// Description : Shares the register-file write port between the pipeline WB
//               stage (priority) and the MDU, whose results wait in a
//               DEPTH-entry buffer. Optional starvation guard enabled by
//               defining REGARB_STARVE_GUARD_EN.
//   clk, reset                  : clock, synchronous active-high reset
//   wb_valid/wb_reg/wb_data     : pipeline writeback request
//   wb_stall                    : hold WB stage (registered, guard only)
//   mdu_valid/mdu_reg/mdu_data  : MDU result, accepted when mdu_ready
//   mdu_ready                   : buffer not full (combinational)
//   RegWrite/Write_register/
//   Write_data                  : registered register-file write port
//   pend_mask                   : registers with an MDU result not yet written
// Revision    : 1.0 - initial release
// ============================================================================
module regfile_wb_arbiter
    import regarb_pkg::*;
#(
    parameter int DEPTH      = 2,
    parameter int STARVE_MAX = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        wb_valid,
    input  logic [4:0]  wb_reg,
    input  logic [31:0] wb_data,
    output logic        wb_stall,
    input  logic        mdu_valid,
    output logic        mdu_ready,
    input  logic [4:0]  mdu_reg,
    input  logic [31:0] mdu_data,
    output logic        RegWrite,
    output logic [4:0]  Write_register,
    output logic [31:0] Write_data,
    output logic [31:0] pend_mask
);

    logic        w_full;
    logic        w_head_valid;
    logic        w_head_stale;
    logic [4:0]  w_head_rd;
    logic [31:0] w_head_data;
    logic [31:0] w_buf_mask;
    logic        w_push;
    logic        w_wb_req;
    logic        w_drain;
    logic        w_grant_wb;
    logic        w_grant_head;
    logic        w_pop;

    logic        r_reg_write;
    logic        r_mdu_write;
    logic [4:0]  r_write_register;
    logic [31:0] r_write_data;

    if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0) || (STARVE_MAX < 1)) begin : g_cfg_invalid
        $error("regfile_wb_arbiter: DEPTH must be a power of two >= 2 and STARVE_MAX >= 1");
    end

    // Writes to r0 are architecturally void: a zero-destination MDU result is
    // acknowledged without taking a slot, and a zero-destination WB request
    // never claims the port.
    assign mdu_ready    = ~w_full;
    assign w_push       = mdu_valid && !w_full && (mdu_reg != REG_ZERO);
    assign w_wb_req     = wb_valid && (wb_reg != REG_ZERO);
    assign w_grant_wb   = w_wb_req && !w_drain;
    assign w_grant_head = w_head_valid && !w_grant_wb;
    assign w_pop        = w_grant_head || w_head_stale;

    // A granted pipeline write is younger than anything buffered, so older MDU
    // results to the same register are dropped.
    regarb_buf #(
        .DEPTH (DEPTH)
    ) u_buf (
        .clk        (clk),
        .reset      (reset),
        .push       (w_push),
        .push_rd    (mdu_reg),
        .push_data  (mdu_data),
        .pop        (w_pop),
        .squash     (w_grant_wb),
        .squash_rd  (wb_reg),
        .head_valid (w_head_valid),
        .head_stale (w_head_stale),
        .head_rd    (w_head_rd),
        .head_data  (w_head_data),
        .full       (w_full),
        .pend_mask  (w_buf_mask)
    );

`ifdef REGARB_STARVE_GUARD_EN
    localparam int                  c_CNT_W   = $clog2(STARVE_MAX + 1);
    localparam logic [c_CNT_W-1:0]  c_CNT_MAX = STARVE_MAX[c_CNT_W-1:0];
    localparam logic [c_CNT_W-1:0]  c_CNT_ONE = c_CNT_W'(1);

    regarb_state_t        r_state;
    regarb_state_t        w_state_next;
    logic [c_CNT_W-1:0]   r_starve_cnt;
    logic [c_CNT_W-1:0]   w_starve_cnt_next;
    logic                 r_wb_stall;
    logic                 w_blocked;

    assign w_drain   = (r_state == DRAIN);
    assign w_blocked = w_head_valid && w_wb_req && !w_drain;
    assign wb_stall  = r_wb_stall;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= IDLE;
            r_starve_cnt <= '0;
            r_wb_stall   <= 1'b0;
        end else begin
            r_state      <= w_state_next;
            r_starve_cnt <= w_starve_cnt_next;
            r_wb_stall   <= (w_state_next == DRAIN);
        end
    end

    // The count includes the current blocked cycle, so DRAIN follows exactly
    // STARVE_MAX consecutive blocked cycles.
    always_comb begin
        w_state_next      = r_state;
        w_starve_cnt_next = r_starve_cnt;
        case (r_state)
            IDLE, WAIT: begin
                if (w_blocked) begin
                    if (r_state == IDLE) begin
                        w_starve_cnt_next = c_CNT_ONE;
                    end else if (r_starve_cnt != c_CNT_MAX) begin
                        w_starve_cnt_next = r_starve_cnt + c_CNT_ONE;
                    end
                    w_state_next = (w_starve_cnt_next == c_CNT_MAX) ? DRAIN : WAIT;
                end else begin
                    w_state_next      = IDLE;
                    w_starve_cnt_next = '0;
                end
            end
            DRAIN: begin
                w_state_next      = IDLE;
                w_starve_cnt_next = '0;
            end
            default: begin
                w_state_next      = IDLE;
                w_starve_cnt_next = '0;
            end
        endcase
    end
`else
    assign w_drain  = 1'b0;
    assign wb_stall = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            r_reg_write      <= 1'b0;
            r_mdu_write      <= 1'b0;
            r_write_register <= REG_ZERO;
            r_write_data     <= '0;
        end else begin
            r_reg_write <= w_grant_wb || w_grant_head;
            r_mdu_write <= w_grant_head;
            if (w_grant_wb) begin
                r_write_register <= wb_reg;
                r_write_data     <= wb_data;
            end else if (w_grant_head) begin
                r_write_register <= w_head_rd;
                r_write_data     <= w_head_data;
            end else begin
                r_write_register <= REG_ZERO;
                r_write_data     <= '0;
            end
        end
    end

    assign RegWrite       = r_reg_write;
    assign Write_register = r_write_register;
    assign Write_data     = r_write_data;

    // An MDU result stays pending until the register file has actually taken
    // it, i.e. through the cycle its write sits on the output port.
    assign pend_mask = w_buf_mask | (r_mdu_write ? reg_onehot(r_write_register) : 32'd0);

endmodule
`default_nettype wire

// File: tb/tb_regfile_wb_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_regfile_wb_arbiter
// Description : Self-checking bench for regfile_wb_arbiter. Expected register
//               writes are queued in program order; a monitor pops and
//               compares each observed write.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_regfile_wb_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        wb_valid;
    logic [4:0]  wb_reg;
    logic [31:0] wb_data;
    logic        wb_stall;
    logic        mdu_valid;
    logic        mdu_ready;
    logic [4:0]  mdu_reg;
    logic [31:0] mdu_data;
    logic        RegWrite;
    logic [4:0]  Write_register;
    logic [31:0] Write_data;
    logic [31:0] pend_mask;

    int          n_vec  = 0;
    int          n_miss = 0;
    logic [36:0] exp_q [$];
    logic [36:0] r_exp;

    regfile_wb_arbiter #(
        .DEPTH      (2),
        .STARVE_MAX (8)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .wb_valid       (wb_valid),
        .wb_reg         (wb_reg),
        .wb_data        (wb_data),
        .wb_stall       (wb_stall),
        .mdu_valid      (mdu_valid),
        .mdu_ready      (mdu_ready),
        .mdu_reg        (mdu_reg),
        .mdu_data       (mdu_data),
        .RegWrite       (RegWrite),
        .Write_register (Write_register),
        .Write_data     (Write_data),
        .pend_mask      (pend_mask)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic sb_push(input logic [4:0] rd, input logic [31:0] data);
        exp_q.push_back({rd, data});
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        wb_valid  = 1'b0;
        mdu_valid = 1'b0;
        repeat (n) step();
    endtask

    // Scoreboard: every register-file write must be the next expected one.
    always @(negedge clk) begin
        if (RegWrite === 1'b1) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_write", 64'(RegWrite), 64'd0);
            end else begin
                r_exp = exp_q.pop_front();
                chk("write", {27'd0, Write_register, Write_data}, {27'd0, r_exp});
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int k;
        int cyc;
        int nstall;
        int first_stall;
        logic stall_now;

        reset     = 1'b1;
        wb_valid  = 1'b0;
        wb_reg    = '0;
        wb_data   = '0;
        mdu_valid = 1'b0;
        mdu_reg   = '0;
        mdu_data  = '0;
        repeat (3) step();

        // ---------------- reset state
        chk("rst_regwrite", RegWrite, 0);
        chk("rst_wreg", Write_register, 0);
        chk("rst_wdata", Write_data, 0);
        chk("rst_stall", wb_stall, 0);
        chk("rst_pend", pend_mask, 0);
        reset = 1'b0;
        step();
        chk("rst_ready", mdu_ready, 1);

        // ---------------- basic accept: r5 = 0x1234
        mdu_valid = 1'b1; mdu_reg = 5'd5; mdu_data = 32'h1234;
        sb_push(5'd5, 32'h1234);
        step();
        mdu_valid = 1'b0;
        chk("basic_pend_c1", pend_mask, 32'h20);
        chk("basic_nowrite_c1", RegWrite, 0);
        step();
        chk("basic_we_c2", RegWrite, 1);
        chk("basic_wreg_c2", Write_register, 5);
        chk("basic_wdata_c2", Write_data, 32'h1234);
        chk("basic_pend_c2", pend_mask, 32'h20);
        step();
        chk("basic_pend_c3", pend_mask, 0);
        chk("basic_nowrite_c3", RegWrite, 0);
        idle(3);

        // ---------------- backpressure / starvation guard
`ifdef REGARB_STARVE_GUARD_EN
        for (int i = 0; i < 9; i++) sb_push(5'd1, 32'hB000_0000 + i);
        sb_push(5'd2, 32'h2222);
        for (int i = 9; i < 12; i++) sb_push(5'd1, 32'hB000_0000 + i);
        sb_push(5'd3, 32'h3333);
`else
        for (int i = 0; i < 12; i++) sb_push(5'd1, 32'hB000_0000 + i);
        sb_push(5'd2, 32'h2222);
        sb_push(5'd3, 32'h3333);
`endif
        k = 0; cyc = 0; nstall = 0; first_stall = -1;
        while (k < 12 && cyc < 40) begin
            wb_valid = 1'b1; wb_reg = 5'd1; wb_data = 32'hB000_0000 + k;
            if (cyc == 0) begin
                mdu_valid = 1'b1; mdu_reg = 5'd2; mdu_data = 32'h2222;
            end else if (cyc == 1) begin
                chk("bp_ready_c1", mdu_ready, 1);
                mdu_valid = 1'b1; mdu_reg = 5'd3; mdu_data = 32'h3333;
            end else begin
                mdu_valid = 1'b0;
            end
            if (cyc == 2) chk("bp_ready_full", mdu_ready, 0);
            stall_now = wb_stall;
            if (stall_now) begin
                nstall++;
                if (first_stall < 0) first_stall = cyc;
            end
            step();
            if (!stall_now) k++;
            cyc++;
        end
        chk("bp_progress", k, 12);
`ifdef REGARB_STARVE_GUARD_EN
        chk("bp_stall_cycle", first_stall, 9);
        chk("bp_stall_count", nstall, 1);
`else
        chk("bp_stall_count", nstall, 0);
`endif
        idle(4);
        chk("bp_drained_pend", pend_mask, 0);

        // ---------------- WAW squash on r7
        wb_valid = 1'b1; wb_reg = 5'd4; wb_data = 32'h4444;
        mdu_valid = 1'b1; mdu_reg = 5'd7; mdu_data = 32'hAAAA;
        sb_push(5'd4, 32'h4444);
        sb_push(5'd7, 32'hBBBB);
        step();
        mdu_valid = 1'b0; wb_reg = 5'd7; wb_data = 32'hBBBB;
        chk("waw_pend_c1", pend_mask, 32'h80);
        step();
        wb_valid = 1'b0;
        chk("waw_pend_c2", pend_mask, 0);
        chk("waw_wdata_c2", Write_data, 32'hBBBB);
        idle(4);

        // ---------------- register zero on both sources
        for (int i = 0; i < 3; i++) begin
            wb_valid = 1'b1; wb_reg = 5'd0; wb_data = 32'hBEEF;
            mdu_valid = 1'b1; mdu_reg = 5'd0; mdu_data = 32'hDEAD;
            chk("r0_ready", mdu_ready, 1);
            step();
            chk("r0_nowrite", RegWrite, 0);
            chk("r0_pend", pend_mask, 0);
        end
        idle(3);

        // ---------------- reset with two results buffered (DRAIN when guarded)
        for (int i = 0; i < 9; i++) sb_push(5'd1, 32'hC000_0000 + i);
        for (int c = 0; c < 9; c++) begin
            wb_valid = 1'b1; wb_reg = 5'd1; wb_data = 32'hC000_0000 + c;
            if (c == 0) begin
                mdu_valid = 1'b1; mdu_reg = 5'd2; mdu_data = 32'h2020;
            end else if (c == 1) begin
                mdu_valid = 1'b1; mdu_reg = 5'd3; mdu_data = 32'h3030;
            end else begin
                mdu_valid = 1'b0;
            end
            step();
        end
`ifdef REGARB_STARVE_GUARD_EN
        chk("rd_stall_in_drain", wb_stall, 1);
`endif
        chk("rd_pend_before", pend_mask, 32'h0C);
        reset = 1'b1; wb_valid = 1'b0; mdu_valid = 1'b0;
        step();
        chk("rd_regwrite", RegWrite, 0);
        chk("rd_wreg", Write_register, 0);
        chk("rd_wdata", Write_data, 0);
        chk("rd_stall", wb_stall, 0);
        chk("rd_pend", pend_mask, 0);
        reset = 1'b0;
        idle(5);
        chk("rd_ready_after", mdu_ready, 1);
        chk("rd_pend_after", pend_mask, 0);

        chk("sb_empty", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
`default_nettype wire
